// File: rtl/ace_snoop_pkg.sv
// Shared types for the ACE snoop responder: opcodes, CR response layout,
// FSM states and the opcode/line-state decoder.
package ace_snoop_pkg;

    typedef enum logic [3:0] {
        SNP_READ_ONCE       = 4'b0000,
        SNP_READ_SHARED     = 4'b0001,
        SNP_READ_CLEAN      = 4'b0010,
        SNP_READ_NSD        = 4'b0011,
        SNP_READ_UNIQUE     = 4'b0111,
        SNP_CLEAN_SHARED    = 4'b1000,
        SNP_CLEAN_INVALID   = 4'b1001,
        SNP_MAKE_INVALID    = 4'b1101
    } snoop_op_e;

    // Bit order on the wire: {WasUnique, IsShared, PassDirty, Error, DataTransfer}
    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } cr_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WAIT_RES,
        ST_RESP
    } state_e;

    // Response plus the cache action requested alongside the lookup.
    typedef struct packed {
        cr_resp_t resp;
        logic     inval;
        logic     clean;
    } snoop_dec_t;

    // Action bits depend only on the opcode; response bits collapse to 0 on a
    // miss for every supported opcode. Unsupported opcodes flag Error only.
    function automatic snoop_dec_t cr_decode(input logic [3:0] op, input logic hit,
                                             input logic dirty, input logic shared);
        snoop_dec_t d;
        d = '0;
        d.resp.was_unique = ~shared;
        case (op)
            SNP_READ_ONCE: begin
                d.resp.data_transfer = 1'b1;
                d.resp.is_shared     = 1'b1;
            end
            SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD: begin
                d.resp.data_transfer = 1'b1;
                d.resp.is_shared     = 1'b1;
                d.resp.pass_dirty    = dirty;
                d.clean              = 1'b1;
            end
            SNP_READ_UNIQUE: begin
                d.resp.data_transfer = 1'b1;
                d.resp.pass_dirty    = dirty;
                d.inval              = 1'b1;
            end
            SNP_CLEAN_INVALID: begin
                d.resp.data_transfer = dirty;
                d.resp.pass_dirty    = dirty;
                d.inval              = 1'b1;
            end
            SNP_CLEAN_SHARED: begin
                d.resp.data_transfer = dirty;
                d.resp.pass_dirty    = dirty;
                d.resp.is_shared     = 1'b1;
                d.clean              = 1'b1;
            end
            SNP_MAKE_INVALID: begin
                d.inval              = 1'b1;
            end
            default: begin
                d.resp       = '0;
                d.resp.error = 1'b1;
            end
        endcase
        if (!hit && !d.resp.error) begin
            d.resp = '0;
        end
        return d;
    endfunction

endpackage

// File: rtl/snoop_cd_serializer.sv
// Serialises one cache line onto the CD channel, beat 0 first.
module snoop_cd_serializer #(
    parameter int DataWidth = 64,
    parameter int LineWidth = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [LineWidth-1:0] line_i,
    input  logic                 cd_ready_i,
    output logic                 cd_valid_o,
    output logic [DataWidth-1:0] cd_data_o,
    output logic                 cd_last_o,
    output logic                 done_o
);
    localparam int NBeats = LineWidth / DataWidth;
    localparam int BeatW  = (NBeats > 1) ? $clog2(NBeats) : 1;

    logic [LineWidth-1:0] line_q, line_d;
    logic [BeatW-1:0]     beat_q, beat_d;
    logic                 active_q, active_d;
    logic [DataWidth-1:0] beats [NBeats];
    logic                 is_last;
    logic                 hs;

    genvar gi;
    generate
        for (gi = 0; gi < NBeats; gi++) begin : g_beat
            assign beats[gi] = line_q[gi*DataWidth +: DataWidth];
        end
    endgenerate

    assign is_last    = (beat_q == BeatW'(NBeats - 1));
    assign hs         = active_q & cd_ready_i;
    assign cd_valid_o = active_q;
    assign cd_data_o  = active_q ? beats[beat_q] : '0;
    assign cd_last_o  = active_q & is_last;
    assign done_o     = hs & is_last;

    // Load a fresh line on start, otherwise advance one beat per handshake.
    always_comb begin
        line_d   = line_q;
        beat_d   = beat_q;
        active_d = active_q;
        if (start_i) begin
            line_d   = line_i;
            beat_d   = '0;
            active_d = 1'b1;
        end else if (hs) begin
            if (is_last) begin
                beat_d   = '0;
                active_d = 1'b0;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    // Beat state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_q   <= '0;
            beat_q   <= '0;
            active_q <= 1'b0;
        end else begin
            line_q   <= line_d;
            beat_q   <= beat_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: AC request -> one cache lookup -> CR response and
// optional CD line transfer. One snoop in flight.
// Optional counters enabled with `define SNOOP_RESP_PERF_CNT_EN.
module ace_snoop_responder
    import ace_snoop_pkg::*;
#(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int LineWidth = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ac_valid_i,
    output logic                 ac_ready_o,
    input  logic [AddrWidth-1:0] ac_addr_i,
    input  logic [3:0]           ac_snoop_i,
    output logic                 cr_valid_o,
    input  logic                 cr_ready_i,
    output logic [4:0]           cr_resp_o,
    output logic                 cd_valid_o,
    input  logic                 cd_ready_i,
    output logic [DataWidth-1:0] cd_data_o,
    output logic                 cd_last_o,
    output logic                 lkp_req_o,
    input  logic                 lkp_gnt_i,
    output logic [AddrWidth-1:0] lkp_addr_o,
    output logic                 lkp_inval_o,
    output logic                 lkp_clean_o,
    input  logic                 lkp_valid_i,
    input  logic                 lkp_hit_i,
    input  logic                 lkp_dirty_i,
    input  logic                 lkp_shared_i,
    input  logic [LineWidth-1:0] lkp_data_i
`ifdef SNOOP_RESP_PERF_CNT_EN
    ,
    output logic [31:0]          perf_hit_cnt_o,
    output logic [31:0]          perf_miss_cnt_o,
    output logic [31:0]          perf_data_cnt_o
`endif
);
    localparam int OffW = $clog2(LineWidth / 8);
    localparam logic [AddrWidth-1:0] OffMask = AddrWidth'((64'd1 << OffW) - 64'd1);

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [3:0]           op_q, op_d;
    logic                 inval_q, inval_d, clean_q, clean_d;
    cr_resp_t             resp_q, resp_d;
    logic                 cr_done_q, cr_done_d, cd_done_q, cd_done_d;
    logic                 ac_ready_q;
    logic                 in_idle, ser_start, ser_done, cr_hs;
    snoop_dec_t           dec;

    // One decoder: in IDLE it classifies the incoming opcode (action, error),
    // later it turns the returned line state into the CR response.
    assign in_idle = (state_q == ST_IDLE);
    assign dec     = cr_decode(in_idle ? ac_snoop_i : op_q,
                               in_idle | lkp_hit_i,
                               ~in_idle & lkp_dirty_i,
                               ~in_idle & lkp_shared_i);

    assign ac_ready_o  = ac_ready_q;
    assign lkp_req_o   = (state_q == ST_LOOKUP);
    assign lkp_addr_o  = addr_q;
    assign lkp_inval_o = lkp_req_o & inval_q;
    assign lkp_clean_o = lkp_req_o & clean_q;
    assign cr_valid_o  = (state_q == ST_RESP) & ~cr_done_q;
    assign cr_resp_o   = resp_q;
    assign cr_hs       = cr_valid_o & cr_ready_i;

    snoop_cd_serializer #(
        .DataWidth (DataWidth),
        .LineWidth (LineWidth)
    ) u_ser (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (ser_start),
        .line_i     (lkp_data_i),
        .cd_ready_i (cd_ready_i),
        .cd_valid_o (cd_valid_o),
        .cd_data_o  (cd_data_o),
        .cd_last_o  (cd_last_o),
        .done_o     (ser_done)
    );

    // Next-state logic for the snoop sequencer.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        op_d      = op_q;
        inval_d   = inval_q;
        clean_d   = clean_q;
        resp_d    = resp_q;
        cr_done_d = cr_done_q;
        cd_done_d = cd_done_q;
        ser_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ac_valid_i && ac_ready_q) begin
                    addr_d    = ac_addr_i & ~OffMask;
                    op_d      = ac_snoop_i;
                    inval_d   = dec.inval;
                    clean_d   = dec.clean;
                    cr_done_d = 1'b0;
                    cd_done_d = 1'b0;
                    if (dec.resp.error) begin
                        resp_d  = dec.resp;
                        state_d = ST_RESP;
                    end else begin
                        resp_d  = '0;
                        state_d = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                if (lkp_gnt_i) begin
                    state_d = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (lkp_valid_i) begin
                    resp_d    = dec.resp;
                    ser_start = dec.resp.data_transfer;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (cr_hs) begin
                    cr_done_d = 1'b1;
                end
                if (ser_done) begin
                    cd_done_d = 1'b1;
                end
                if ((cr_done_q || cr_hs) &&
                    (!resp_q.data_transfer || cd_done_q || ser_done)) begin
                    cr_done_d = 1'b0;
                    cd_done_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; ready is registered so it is low during reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            op_q       <= '0;
            inval_q    <= 1'b0;
            clean_q    <= 1'b0;
            resp_q     <= '0;
            cr_done_q  <= 1'b0;
            cd_done_q  <= 1'b0;
            ac_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            inval_q    <= inval_d;
            clean_q    <= clean_d;
            resp_q     <= resp_d;
            cr_done_q  <= cr_done_d;
            cd_done_q  <= cd_done_d;
            ac_ready_q <= (state_d == ST_IDLE);
        end
    end

`ifdef SNOOP_RESP_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, data_cnt_q;
    logic        res_evt;

    assign res_evt         = (state_q == ST_WAIT_RES) & lkp_valid_i;
    assign perf_hit_cnt_o  = hit_cnt_q;
    assign perf_miss_cnt_o = miss_cnt_q;
    assign perf_data_cnt_o = data_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            data_cnt_q <= '0;
        end else begin
            if (res_evt && lkp_hit_i && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (res_evt && !lkp_hit_i && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
            if (cr_hs && resp_q.data_transfer && (data_cnt_q != '1)) begin
                data_cnt_q <= data_cnt_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder (default build, counters absent).
module tb_ace_snoop_responder;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         ac_valid_i = 1'b0;
    logic         ac_ready_o;
    logic [63:0]  ac_addr_i = '0;
    logic [3:0]   ac_snoop_i = '0;
    logic         cr_valid_o;
    logic         cr_ready_i = 1'b0;
    logic [4:0]   cr_resp_o;
    logic         cd_valid_o;
    logic         cd_ready_i = 1'b0;
    logic [63:0]  cd_data_o;
    logic         cd_last_o;
    logic         lkp_req_o;
    logic         lkp_gnt_i = 1'b0;
    logic [63:0]  lkp_addr_o;
    logic         lkp_inval_o;
    logic         lkp_clean_o;
    logic         lkp_valid_i = 1'b0;
    logic         lkp_hit_i = 1'b0;
    logic         lkp_dirty_i = 1'b0;
    logic         lkp_shared_i = 1'b0;
    logic [127:0] lkp_data_i = '0;

    ace_snoop_responder dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ac_valid_i   (ac_valid_i),
        .ac_ready_o   (ac_ready_o),
        .ac_addr_i    (ac_addr_i),
        .ac_snoop_i   (ac_snoop_i),
        .cr_valid_o   (cr_valid_o),
        .cr_ready_i   (cr_ready_i),
        .cr_resp_o    (cr_resp_o),
        .cd_valid_o   (cd_valid_o),
        .cd_ready_i   (cd_ready_i),
        .cd_data_o    (cd_data_o),
        .cd_last_o    (cd_last_o),
        .lkp_req_o    (lkp_req_o),
        .lkp_gnt_i    (lkp_gnt_i),
        .lkp_addr_o   (lkp_addr_o),
        .lkp_inval_o  (lkp_inval_o),
        .lkp_clean_o  (lkp_clean_o),
        .lkp_valid_i  (lkp_valid_i),
        .lkp_hit_i    (lkp_hit_i),
        .lkp_dirty_i  (lkp_dirty_i),
        .lkp_shared_i (lkp_shared_i),
        .lkp_data_i   (lkp_data_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Per-snoop observations.
    int          r_lat, r_crcnt, r_nbeats, r_done, r_exit, r_unstable;
    logic        r_req, r_clean, r_inval, r_exited;
    logic [4:0]  r_resp;
    logic [63:0] r_addr;
    logic [63:0] r_beat [4];
    logic        r_last [4];

    task automatic run_snoop(input logic [3:0] op, input logic [63:0] addr,
                             input logic hit, input logic dirty, input logic shared,
                             input logic [127:0] line, input int cr_stall, input bit cd_tog);
        int   cr_first, cr_hs_cyc, cd_last_cyc, w;
        bit   prev_cr_stall, prev_cd_stall, nr;
        logic [4:0]  prev_resp;
        logic [63:0] prev_data;
        logic        prev_last;
        r_lat = -1; r_crcnt = 0; r_nbeats = 0; r_exit = 0; r_unstable = 0;
        r_req = 0; r_clean = 0; r_inval = 0; r_exited = 0; r_resp = '0; r_addr = '0;
        for (int i = 0; i < 4; i++) begin r_beat[i] = '0; r_last[i] = 1'b0; end
        cr_first = 0; cr_hs_cyc = 0; cd_last_cyc = 0;
        prev_cr_stall = 0; prev_cd_stall = 0; prev_resp = '0; prev_data = '0; prev_last = 0;
        w = 0;
        while (!ac_ready_o && w < 50) begin @(negedge clk_i); w++; end
        if (!ac_ready_o) chk("ac_ready_wait", 64'd0, 64'd1);
        lkp_hit_i = hit; lkp_dirty_i = dirty; lkp_shared_i = shared; lkp_data_i = line;
        ac_valid_i = 1'b1; ac_addr_i = addr; ac_snoop_i = op;
        @(posedge clk_i);
        #1 ac_valid_i = 1'b0;
        for (int cyc = 1; cyc <= 100 && !r_exited; cyc++) begin
            @(negedge clk_i);
            if (ac_ready_o) begin
                r_exited = 1'b1;
                r_exit = cyc;
            end else begin
                lkp_valid_i = 1'b0;
                if (lkp_req_o) begin
                    r_req = 1'b1; r_clean |= lkp_clean_o; r_inval |= lkp_inval_o;
                    r_addr = lkp_addr_o;
                    lkp_gnt_i = 1'b1;
                end else begin
                    if (lkp_gnt_i) lkp_valid_i = 1'b1;
                    lkp_gnt_i = 1'b0;
                end
                if (prev_cr_stall && (!cr_valid_o || cr_resp_o !== prev_resp)) r_unstable++;
                if (cr_valid_o) begin
                    if (r_lat < 0) begin r_lat = cyc; r_resp = cr_resp_o; cr_first = cyc; end
                    nr = (cyc - cr_first) >= cr_stall;
                    cr_ready_i = nr;
                    if (nr) begin r_crcnt++; cr_hs_cyc = cyc; end
                    prev_cr_stall = !nr; prev_resp = cr_resp_o;
                end else begin
                    cr_ready_i = 1'b0; prev_cr_stall = 0;
                end
                if (prev_cd_stall && (!cd_valid_o || cd_data_o !== prev_data || cd_last_o !== prev_last))
                    r_unstable++;
                if (cd_valid_o) begin
                    nr = cd_tog ? (cyc % 2 == 1) : 1'b1;
                    cd_ready_i = nr;
                    if (nr) begin
                        if (r_nbeats < 4) begin r_beat[r_nbeats] = cd_data_o; r_last[r_nbeats] = cd_last_o; end
                        r_nbeats++;
                        if (cd_last_o) cd_last_cyc = cyc;
                    end
                    prev_cd_stall = !nr; prev_data = cd_data_o; prev_last = cd_last_o;
                end else begin
                    cd_ready_i = 1'b0; prev_cd_stall = 0;
                end
            end
        end
        lkp_gnt_i = 1'b0; lkp_valid_i = 1'b0; cr_ready_i = 1'b0; cd_ready_i = 1'b0;
        r_done = (cr_hs_cyc > cd_last_cyc) ? cr_hs_cyc : cd_last_cyc;
        if (!r_exited) chk("snoop_timeout", 64'd0, 64'd1);
        $display("snoop op=%b addr=%h resp=%b lat=%0d beats=%0d exit=%0d", op, addr, r_resp, r_lat, r_nbeats, r_exit);
    endtask

    task automatic chk_common(input string t, input logic [4:0] resp, input int crcnt);
        chk({t, "_resp"}, 64'(r_resp), 64'(resp));
        chk({t, "_crcnt"}, 64'(r_crcnt), 64'(crcnt));
        chk({t, "_exit"}, 64'(r_exit), 64'(r_done + 1));
        chk({t, "_stable"}, 64'(r_unstable), 64'd0);
    endtask

    task automatic chk_beats(input string t, input logic [127:0] line);
        chk({t, "_nbeats"}, 64'(r_nbeats), 64'd2);
        chk({t, "_beat0"}, r_beat[0], line[63:0]);
        chk({t, "_beat1"}, r_beat[1], line[127:64]);
        chk({t, "_last0"}, 64'(r_last[0]), 64'd0);
        chk({t, "_last1"}, 64'(r_last[1]), 64'd1);
    endtask

    logic [127:0] l1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    logic [127:0] l2 = 128'hdead_beef_0bad_f00d_cafe_babe_1234_5678;
    logic [127:0] l3 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_outs", 64'(|{ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
                               lkp_req_o, lkp_addr_o, lkp_inval_o, lkp_clean_o}), 64'd0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rst_ac_ready", 64'(ac_ready_o), 64'd1);

        // ReadShared hit dirty shared, unaligned address
        run_snoop(4'b0001, 64'h0000_0000_8000_0047, 1, 1, 1, l1, 0, 0);
        chk_common("rs", 5'b01101, 1);
        chk_beats("rs", l1);
        chk("rs_lat", 64'(r_lat), 64'd3);
        chk("rs_clean", 64'(r_clean), 64'd1);
        chk("rs_inval", 64'(r_inval), 64'd0);
        chk("rs_addr", r_addr, 64'h0000_0000_8000_0040);

        // ReadOnce hit clean unique
        run_snoop(4'b0000, 64'h1234_0010, 1, 0, 0, l2, 0, 0);
        chk_common("ro", 5'b11001, 1);
        chk_beats("ro", l2);
        chk("ro_action", 64'({r_clean, r_inval}), 64'd0);

        // ReadUnique miss
        run_snoop(4'b0111, 64'h2000_0000, 0, 0, 0, l1, 0, 0);
        chk_common("ru_miss", 5'b00000, 1);
        chk("ru_miss_nbeats", 64'(r_nbeats), 64'd0);
        chk("ru_miss_inval", 64'(r_inval), 64'd1);

        // CleanInvalid hit clean shared, then hit dirty unique
        run_snoop(4'b1001, 64'h3000_0080, 1, 0, 1, l1, 0, 0);
        chk_common("ci_clean", 5'b00000, 1);
        chk("ci_clean_nbeats", 64'(r_nbeats), 64'd0);
        chk("ci_clean_inval", 64'(r_inval), 64'd1);
        run_snoop(4'b1001, 64'h3000_0080, 1, 1, 0, l3, 0, 0);
        chk_common("ci_dirty", 5'b10101, 1);
        chk_beats("ci_dirty", l3);

        // Unsupported opcode
        run_snoop(4'b0101, 64'h4000_0000, 1, 1, 0, l1, 0, 0);
        chk_common("bad_op", 5'b00010, 1);
        chk("bad_op_req", 64'(r_req), 64'd0);
        chk("bad_op_lat", 64'(r_lat), 64'd1);
        chk("bad_op_nbeats", 64'(r_nbeats), 64'd0);

        // Backpressure: CR stalled 5 cycles, CD ready toggling
        run_snoop(4'b0111, 64'h5000_0040, 1, 1, 0, l2, 5, 1);
        chk_common("bp", 5'b10101, 1);
        chk_beats("bp", l2);
        chk("bp_exit_cyc", 64'(r_exit), 64'd9);

        // MakeInvalid hit dirty unique
        run_snoop(4'b1101, 64'h6000_0000, 1, 1, 0, l1, 0, 0);
        chk_common("mi", 5'b10000, 1);
        chk("mi_nbeats", 64'(r_nbeats), 64'd0);
        chk("mi_inval", 64'(r_inval), 64'd1);

        // CleanShared hit dirty shared
        run_snoop(4'b1000, 64'h7000_00c0, 1, 1, 1, l3, 0, 0);
        chk_common("cs", 5'b01101, 1);
        chk_beats("cs", l3);
        chk("cs_clean", 64'(r_clean), 64'd1);

        // Reset while waiting for the lookup result
        @(negedge clk_i);
        ac_valid_i = 1'b1; ac_addr_i = 64'h8000_0040; ac_snoop_i = 4'b0001;
        @(posedge clk_i);
        #1 ac_valid_i = 1'b0;
        @(negedge clk_i);
        chk("mid_req", 64'(lkp_req_o), 64'd1);
        lkp_gnt_i = 1'b1;
        @(negedge clk_i);
        lkp_gnt_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_outs", 64'(|{ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
                                   lkp_req_o, lkp_addr_o, lkp_inval_o, lkp_clean_o}), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_snoop(4'b0010, 64'h9000_0040, 1, 0, 0, l1, 0, 0);
        chk_common("post_rst", 5'b11001, 1);
        chk_beats("post_rst", l1);
        chk("post_rst_lat", 64'(r_lat), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
